// File: rtl/frame_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_fill_ctrl
// Purpose  : Collects five handshaken bytes into the 40-bit shift register and
//            hands the completed frame downstream. Optional macro
//            FRAME_TIMEOUT_EN adds an inter-byte timeout that drops partial frames.
// Revision : 1.0 - initial release
// ============================================================================
module frame_fill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        sr_shift,
  output logic [7:0]  sr_data,
  input  logic [39:0] sr_P,
  output logic        frame_valid,
  output logic [39:0] frame_data,
  input  logic        frame_ready,
  output logic [2:0]  byte_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] byte_cnt_q;
  logic       w_accept;

  // A zero timeout would abandon a frame before it could ever grow.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
  end

  assign in_ready    = (state_q != S_FULL);
  assign w_accept    = in_valid & in_ready;
  assign sr_shift    = w_accept;
  assign sr_data     = in_data;
  assign frame_valid = (state_q == S_FULL);
  assign frame_data  = frame_valid ? sr_P : 40'd0;
  assign byte_cnt    = byte_cnt_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic          timeout_err_q;

  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 3'd0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (w_accept) begin
            state_q    <= S_FILL;
            byte_cnt_q <= 3'd1;
          end
        end
        S_FILL: begin
          // An accept on the final idle cycle takes priority over the timeout.
          if (w_accept) begin
            timer_q <= '0;
            if (byte_cnt_q == 3'd4) begin
              state_q    <= S_FULL;
              byte_cnt_q <= 3'd0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end else if (timer_q == c_TIMER_LAST) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= 3'd0;
            timer_q       <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_FULL: begin
          timer_q <= '0;
          if (frame_ready) state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          byte_cnt_q <= 3'd0;
          timer_q    <= '0;
        end
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            state_q    <= S_FILL;
            byte_cnt_q <= 3'd1;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (byte_cnt_q == 3'd4) begin
              state_q    <= S_FULL;
              byte_cnt_q <= 3'd0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        S_FULL: begin
          if (frame_ready) state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          byte_cnt_q <= 3'd0;
        end
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_fill_ctrl
// Purpose  : Directed self-checking bench for frame_fill_ctrl, including a
//            behavioural model of the 40-bit shift register datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_fill_ctrl;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        sr_shift;
  logic [7:0]  sr_data;
  logic [39:0] sr_P;
  logic        frame_valid;
  logic [39:0] frame_data;
  logic        frame_ready = 1'b0;
  logic [2:0]  byte_cnt;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int te_seen  = 0;

  always #5 clk = ~clk;

  frame_fill_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sr_shift    (sr_shift),
    .sr_data     (sr_data),
    .sr_P        (sr_P),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .byte_cnt    (byte_cnt),
    .timeout_err (timeout_err)
  );

  // Shift register datapath shares the controller reset.
  always @(posedge clk) begin
    if (!nRst)         sr_P <= 40'd0;
    else if (sr_shift) sr_P <= {sr_P[31:0], sr_data};
  end

  always @(posedge clk) if (timeout_err) te_seen = te_seen + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Each cycle: inputs already set after the previous edge, check at negedge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [2:0] exp_cnt);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    check_eq("send_shift", 64'(sr_shift), 64'd1);
    check_eq("send_cnt", 64'(byte_cnt), 64'(exp_cnt));
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8], 3'(i));
  endtask

  task automatic take_frame(input string tag, input logic [39:0] f);
    in_valid    = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_fv"}, 64'(frame_valid), 64'd1);
    check_eq({tag, "_fd"}, 64'(frame_data), 64'(f));
    check_eq({tag, "_nordy"}, 64'(in_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_fv_clr"}, 64'(frame_valid), 64'd0);
    check_eq({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    next_cycle();
  endtask

  initial begin
    int shifts;
    // Reset state
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_fv", 64'(frame_valid), 64'd0);
    check_eq("rst_fd", 64'(frame_data), 64'd0);
    check_eq("rst_shift", 64'(sr_shift), 64'd0);
    check_eq("rst_cnt", 64'(byte_cnt), 64'd0);
    check_eq("rst_te", 64'(timeout_err), 64'd0);
    nRst = 1'b1;
    next_cycle();

    // Basic frame, back-to-back, counting shift pulses including the FULL cycle
    frame_ready = 1'b1;
    shifts = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(i + 1);
      @(negedge clk);
      if (sr_shift) shifts++;
      check_eq("basic_cnt", 64'(byte_cnt), 64'(i));
      check_eq("basic_data", 64'(sr_data), 64'(8'h11 * 8'(i + 1)));
      next_cycle();
    end
    @(negedge clk);
    if (sr_shift) shifts++;
    check_eq("basic_fv", 64'(frame_valid), 64'd1);
    check_eq("basic_fd", 64'(frame_data), 64'h11_2233_4455);
    check_eq("basic_full_rdy", 64'(in_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    if (sr_shift) shifts++;
    check_eq("basic_shifts", 64'(shifts), 64'd6);
    check_eq("basic_rdy_back", 64'(in_ready), 64'd1);
    check_eq("basic_fv_clr", 64'(frame_valid), 64'd0);
    in_valid = 1'b0;
    next_cycle();

    // Backpressure with a pending 0x99
    frame_ready = 1'b0;
    send_frame(40'hA1_A2A3_A4A5);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_rdy", 64'(in_ready), 64'd0);
      check_eq("bp_shift", 64'(sr_shift), 64'd0);
      check_eq("bp_fv", 64'(frame_valid), 64'd1);
      check_eq("bp_fd", 64'(frame_data), 64'hA1_A2A3_A4A5);
      next_cycle();
    end
    frame_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_hs_shift", 64'(sr_shift), 64'd0);
    check_eq("bp_hs_fd", 64'(frame_data), 64'hA1_A2A3_A4A5);
    next_cycle();
    @(negedge clk);
    check_eq("bp_99_rdy", 64'(in_ready), 64'd1);
    check_eq("bp_99_shift", 64'(sr_shift), 64'd1);
    check_eq("bp_99_cnt", 64'(byte_cnt), 64'd0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_99_cnt1", 64'(byte_cnt), 64'd1);

    // Reset mid-fill: two more bytes make three, then one reset edge
    next_cycle();
    send_byte(8'h9A, 3'd1);
    send_byte(8'h9B, 3'd2);
    nRst = 1'b0;
    next_cycle();
    nRst = 1'b1;
    @(negedge clk);
    check_eq("mrst_cnt", 64'(byte_cnt), 64'd0);
    check_eq("mrst_rdy", 64'(in_ready), 64'd1);
    check_eq("mrst_fv", 64'(frame_valid), 64'd0);
    check_eq("mrst_fd", 64'(frame_data), 64'd0);
    check_eq("mrst_shift", 64'(sr_shift), 64'd0);
    check_eq("mrst_te_seen", 64'(te_seen), 64'd0);
    next_cycle();
    send_frame(40'hC1_C2C3_C4C5);
    take_frame("mrst_frame", 40'hC1_C2C3_C4C5);

`ifdef FRAME_TIMEOUT_EN
    // Timeout: eight idle cycles after the second accept
    send_byte(8'h01, 3'd0);
    send_byte(8'h02, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq("to_wait_te", 64'(timeout_err), 64'd0);
      check_eq("to_wait_cnt", 64'(byte_cnt), 64'd2);
      next_cycle();
    end
    @(negedge clk);
    check_eq("to_pulse", 64'(timeout_err), 64'd1);
    check_eq("to_cnt0", 64'(byte_cnt), 64'd0);
    next_cycle();
    @(negedge clk);
    check_eq("to_pulse_end", 64'(timeout_err), 64'd0);
    check_eq("to_pulse_once", 64'(te_seen), 64'd1);
    next_cycle();
    send_frame(40'hB1_B2B3_B4B5);
    take_frame("to_frame", 40'hB1_B2B3_B4B5);

    // Timeout race: accept on the eighth idle cycle
    send_byte(8'h05, 3'd0);
    send_byte(8'h06, 3'd1);
    repeat (7) next_cycle();
    send_byte(8'h07, 3'd2);
    @(negedge clk);
    check_eq("race_te", 64'(timeout_err), 64'd0);
    check_eq("race_cnt", 64'(byte_cnt), 64'd3);
    next_cycle();
    send_byte(8'h08, 3'd3);
    send_byte(8'h09, 3'd4);
    take_frame("race_frame", 40'h06_0708_0905 >> 0 == 0 ? 40'd0 : 40'h05_0607_0809);
    check_eq("race_te_total", 64'(te_seen), 64'd1);
`else
    // Macro off: partial frame survives a long idle
    send_byte(8'h31, 3'd0);
    send_byte(8'h32, 3'd1);
    repeat (5000) next_cycle();
    @(negedge clk);
    check_eq("off_cnt", 64'(byte_cnt), 64'd2);
    check_eq("off_te_seen", 64'(te_seen), 64'd0);
    check_eq("off_te", 64'(timeout_err), 64'd0);
    next_cycle();
    send_byte(8'h33, 3'd2);
    send_byte(8'h34, 3'd3);
    send_byte(8'h35, 3'd4);
    take_frame("off_frame", 40'h31_3233_3435);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
